// File: rtl/ddr_test_pkg.sv
// Shared definitions for the DDR traffic-generator write engine and read checker:
// FSM encoding, data-width derivation and the per-lane test pattern.
package ddr_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_AW       = 3'd1,
    ST_WDATA    = 3'd2,
    ST_DONE     = 3'd3,
    ST_WAIT_LOW = 3'd4
  } wr_state_e;

  localparam int LANE_W = 32;

  function automatic int data_width(input int dq_width);
    return dq_width * 8;
  endfunction

  function automatic int lane_count(input int dw);
    return dw / LANE_W;
  endfunction

  // Lane i of beat k is addr + 8k + i, wrapping at 32 bits.
  function automatic logic [31:0] pattern_lane(input logic [31:0] addr,
                                               input logic [31:0] beat,
                                               input logic [31:0] lane);
    return addr + (beat << 3) + lane;
  endfunction

endpackage

// File: rtl/ddr_test_data_gen.sv
// Combinational test-pattern generator: one DW-wide beat from start address and beat index.
module ddr_test_data_gen
  import ddr_test_pkg::*;
#(
  parameter int ADDR_WIDTH = 28,
  parameter int DW         = 128
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [3:0]            beat,
  output logic [DW-1:0]         data
);

  localparam int LANES = lane_count(DW);

  logic [31:0] addr_32;
  assign addr_32 = 32'(addr);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign data[i*LANE_W +: LANE_W] = pattern_lane(addr_32, {28'd0, beat}, 32'(i));
  end

endmodule

// File: rtl/ddr_test_wr_ctrl.sv
// AXI write-burst engine: latches a randomised burst on write_en, issues AW then W beats
// carrying a deterministic pattern, and pulses write_done_p once the last beat is taken.
//
// state       | meaning
// ST_IDLE     | waiting for write_en; latches addr/id/len on request
// ST_AW       | awvalid high until the address handshake
// ST_WDATA    | wvalid high, one beat per wvalid&wready, wlast on beat len_q
// ST_DONE     | one-cycle write_done_p, burst counter increments
// ST_WAIT_LOW | holds off until write_en drops so a stale level cannot re-trigger
module ddr_test_wr_ctrl
  import ddr_test_pkg::*;
#(
  parameter  int CTRL_ADDR_WIDTH = 28,
  parameter  int MEM_DQ_WIDTH    = 16,
  localparam int DW              = MEM_DQ_WIDTH * 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       write_en,
  input  logic [CTRL_ADDR_WIDTH-1:0] random_rw_addr,
  input  logic [3:0]                 random_axi_id,
  input  logic [3:0]                 random_axi_len,
  output logic                       write_done_p,
  output logic [CTRL_ADDR_WIDTH-1:0] axi_awaddr,
  output logic [3:0]                 axi_awid,
  output logic [3:0]                 axi_awlen,
  output logic                       axi_awvalid,
  input  logic                       axi_awready,
  output logic [DW-1:0]              axi_wdata,
  output logic [DW/8-1:0]            axi_wstrb,
  output logic                       axi_wlast,
  output logic                       axi_wvalid,
  input  logic                       axi_wready,
  output logic [31:0]                wr_burst_cnt
);

  wr_state_e                  state, state_nxt;
  logic [CTRL_ADDR_WIDTH-1:0] addr_q;
  logic [3:0]                 id_q;
  logic [3:0]                 len_q;
  logic [3:0]                 beat_cnt;
  logic [DW-1:0]              pattern;
  logic                       last_beat;

  assign last_beat = (beat_cnt == len_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (write_en)                 state_nxt = ST_AW;
      ST_AW:       if (axi_awready)              state_nxt = ST_WDATA;
      ST_WDATA:    if (axi_wready && last_beat)  state_nxt = ST_DONE;
      ST_DONE:                                   state_nxt = ST_WAIT_LOW;
      ST_WAIT_LOW: if (!write_en)                state_nxt = ST_IDLE;
      default:                                   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q       <= '0;
      id_q         <= '0;
      len_q        <= '0;
      beat_cnt     <= '0;
      wr_burst_cnt <= '0;
    end else begin
      if (state == ST_IDLE && write_en) begin
        addr_q   <= random_rw_addr;
        id_q     <= random_axi_id;
        len_q    <= random_axi_len;
        beat_cnt <= '0;
      end else if (state == ST_WDATA && axi_wready && !last_beat) begin
        beat_cnt <= beat_cnt + 4'd1;
      end
      if (state == ST_DONE) wr_burst_cnt <= wr_burst_cnt + 32'd1;
    end
  end

  ddr_test_data_gen #(
    .ADDR_WIDTH (CTRL_ADDR_WIDTH),
    .DW         (DW)
  ) u_data_gen (
    .addr (addr_q),
    .beat (beat_cnt),
    .data (pattern)
  );

  // Data bus is forced to zero outside WDATA so reset and idle show all-zero outputs.
  assign axi_awvalid  = (state == ST_AW);
  assign axi_awaddr   = addr_q;
  assign axi_awid     = id_q;
  assign axi_awlen    = len_q;
  assign axi_wvalid   = (state == ST_WDATA);
  assign axi_wlast    = axi_wvalid && last_beat;
  assign axi_wdata    = axi_wvalid ? pattern : '0;
  assign axi_wstrb    = {(DW/8){axi_wvalid}};
  assign write_done_p = (state == ST_DONE);

endmodule

// File: doc/ddr_test_wr_ctrl.md
Name: ddr_test_wr_ctrl

Overview:
AXI write-burst engine for the DDR3 example-design traffic generator. Sits directly downstream of the test main controller. On a rising write_en it latches the randomised address, ID and length, then issues one AXI write burst with a deterministic data pattern. It returns a one-cycle write_done_p, which the main controller uses to end its write phase and advance its PRBS.

Parameters:
CTRL_ADDR_WIDTH, 28, controller/AXI address width in bits
MEM_DQ_WIDTH, 16, DDR DQ width; AXI data width DW = MEM_DQ_WIDTH*8 (128 at default); DW must be a multiple of 32

Ports:
clk  in  1  system clock, all logic rising-edge
rst_n  in  1  asynchronous active-low reset
write_en  in  1  level request from main controller; held high until write_done_p is seen, low one cycle later
random_rw_addr  in  CTRL_ADDR_WIDTH  burst start address, sampled at start only
random_axi_id  in  4  burst ID, sampled at start only
random_axi_len  in  4  burst length minus 1 (1..16 beats), sampled at start only
write_done_p  out  1  one-cycle pulse after last W beat accepted
axi_awaddr  out  CTRL_ADDR_WIDTH  write address
axi_awid  out  4  write ID
axi_awlen  out  4  burst length minus 1
axi_awvalid  out  1  address valid
axi_awready  in  1  address ready
axi_wdata  out  DW  write data
axi_wstrb  out  DW/8  byte strobes, all ones whenever wvalid
axi_wlast  out  1  last beat flag
axi_wvalid  out  1  data valid
axi_wready  in  1  data ready
wr_burst_cnt  out  32  count of completed bursts, wraps 2^32-1 -> 0

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; latched addr/id/len 0; beat counter 0; wr_burst_cnt 0. Reset asserted mid-burst abandons the burst immediately; no done pulse.
- States: IDLE, AW, WDATA, DONE, WAIT_LOW.
- IDLE: when write_en=1, latch addr_q/id_q/len_q from the random_* inputs, clear beat_cnt, go to AW. awvalid rises on the next cycle; start latency is 1 cycle.
- AW: awvalid=1; awaddr/awid/awlen = latched values, stable until handshake. On awvalid&awready: awvalid<=0, go to WDATA, wvalid<=1 next cycle. AW and W never overlap.
- WDATA: wvalid held 1 until the last beat is accepted. wdata/wlast change only on wvalid&wready.
  - wlast=1 exactly when beat_cnt==len_q.
  - On a handshake with beat_cnt==len_q: wvalid<=0, wlast<=0, go to DONE. Otherwise beat_cnt++.
  - wready low stalls indefinitely with data held.
- DONE: write_done_p=1 for exactly this cycle; wr_burst_cnt++; go to WAIT_LOW.
- WAIT_LOW: stay until write_en=0, then IDLE. This prevents a re-trigger from the stale high level the cycle after done. If write_en is already 0, WAIT_LOW lasts 1 cycle.
- Back-to-back bursts: the minimum gap from done pulse to next awvalid is 3 cycles (WAIT_LOW, IDLE latch, AW).
- Data pattern: wdata is DW/32 lanes. Lane i of beat k = (ZEXT32(addr_q) + (k<<3) + i) mod 2^32.
  - Pure function of (addr_q, k), so the read checker regenerates it.
  - len_q=15 gives k = 0..15.
- write_en falling mid-burst is ignored; the burst always completes (AXI forbids abandonment).
- Inputs random_* changing after latch have no effect.

Decomposition:
- Shared package ddr_test_pkg: state encoding constants; DW and lane-count derivation; pattern function pattern_lane(addr, beat, lane). The read-check block reuses this function.
- One sub-module: ddr_test_data_gen (combinational, addr_q + beat_cnt -> DW data) instantiated here and in the read checker.
- Everything else stays in the top FSM.

Test Plan:
- Single beat: addr=0x000_0080, id=3, len=0, awready and wready tied 1, write_en 0->1 -> awvalid on cycle+1 with awaddr=0x80, awid=3, awlen=0; one W beat with wlast=1 and lanes 0x80,0x81,0x82,0x83; write_done_p once; wr_burst_cnt=1.
- Full burst: len=15, addr=0x100 -> 16 W beats, wlast only on beat 15, beat 15 lane0=0x178; exactly one done pulse.
- Backpressure: awready low 5 cycles, then wready toggled 1/0 -> awaddr stable while awvalid=1 and unaccepted; no beat skipped or duplicated; beat count = len+1.
- Handshake with main controller: model write_en dropping 1 cycle after done, re-raised 2 cycles later with new random_* -> exactly one burst per write_en rise; second burst uses the new addr; no extra burst from the stale level.
- Reset mid-burst: assert rst_n=0 during beat 3 of 8 -> all outputs 0 asynchronously, no done pulse, wr_burst_cnt=0; after release, the next write_en starts a clean burst from beat 0.
